// File: rtl/alu_cmd_issue.sv
// Command-issue stage for an 8-bit registered ALU. It queues {a,b,sel} commands and issues one at a time.
// Each result is captured after the ALU's one-clock latency and offered downstream on a valid/ready port.
module alu_cmd_issue #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [3:0]    in_sel,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [3:0]    out_sel,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 * W + 4;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Valid is never withdrawn before its transfer, and the payload holds steady while valid waits.
  typedef enum logic [1:0] {IDLE, WAIT, CAPT, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign head     = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: state_nxt = CAPT;
      CAPT: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset: count and the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_sel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        alu_a   <= head[EW-1 -: W];
        alu_b   <= head[W+3 -: W];
        alu_sel <= head[3:0];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // alu_sel is still the issued opcode here; it only moves on a later pop.
      if (state == CAPT) begin
        out_valid <= 1'b1;
        out_data  <= alu_res;
        out_sel   <= alu_sel;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
